// File: rtl/eth_irq_coalescer_if.sv
// Avalon-MM slave bus between the Nios II CPU and the Ethernet interrupt coalescer.
interface eth_irq_coalescer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/eth_irq_coalescer.sv
// Ethernet interrupt coalescer: edge-captured pending bits with masks and a
// single irq line, driven either directly or through count/timeout coalescing.
module eth_irq_coalescer #(
  parameter int NUM_SRC = 8,
  parameter int TIMER_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  eth_irq_coalescer_if.slave  bus,
  input  logic [NUM_SRC-1:0]  src_in,
  output logic                irq
);

  localparam int NEV_W = $clog2(NUM_SRC + 1);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CTRL    = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd4;
  localparam logic [2:0] ADDR_VECTOR  = 3'd5;
  localparam logic [2:0] ADDR_EVCNT   = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] d1, d2, d3;
  logic [NUM_SRC-1:0] src_edge;
  logic [NUM_SRC-1:0] masked_edge;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mp;
  logic [NUM_SRC-1:0] w1c_bits;
  logic               coal_en;
  logic [7:0]         cnt_th;
  logic [TIMER_W-1:0] timeout;

  state_t             state, state_nxt;
  logic [7:0]         evcnt, evcnt_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               irq_nxt;

  logic               wr_en;
  logic [NEV_W-1:0]   nev;
  logic [7:0]         threshold;
  logic [8:0]         evcnt_sum;
  logic [7:0]         evcnt_sat;
  logic [TIMER_W:0]   timer_inc;
  logic [TIMER_W-1:0] timer_sat;
  logic               timeout_hit;
  logic [3:0]         vec_idx;
  logic [31:0]        rd_mux;

  assign wr_en       = bus.chipselect & ~bus.write_n;
  assign src_edge    = d2 & ~d3;
  assign masked_edge = src_edge & mask;
  assign mp          = pending & mask;
  assign w1c_bits    = (wr_en && bus.address == ADDR_PENDING) ? bus.writedata[NUM_SRC-1:0] : '0;

  // A threshold of zero behaves like one so an enabled event always counts toward firing.
  assign threshold   = (cnt_th == 8'd0) ? 8'd1 : cnt_th;
  assign evcnt_sum   = {1'b0, evcnt} + 9'(nev);
  assign evcnt_sat   = evcnt_sum[8] ? 8'hFF : evcnt_sum[7:0];
  assign timer_inc   = {1'b0, timer} + {{TIMER_W{1'b0}}, 1'b1};
  assign timer_sat   = timer_inc[TIMER_W] ? timer : timer_inc[TIMER_W-1:0];
  assign timeout_hit = (timeout != '0) && (timer_inc >= {1'b0, timeout});

  // Synchronize the asynchronous event levels and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d1 <= src_in;
      d2 <= d1;
      d3 <= d2;
    end
  end

  // Count enabled rising edges seen this cycle.
  always_comb begin
    nev = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nev = nev + NEV_W'(masked_edge[i]);
    end
  end

  // Lowest-numbered enabled pending source, searched from the top so the lowest wins.
  always_comb begin
    vec_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mp[i]) begin
        vec_idx = 4'(i);
      end
    end
  end

  // Software-visible registers; a new edge beats a simultaneous W1C on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      mask    <= '0;
      coal_en <= 1'b0;
      cnt_th  <= 8'd0;
      timeout <= '0;
    end else begin
      pending <= src_edge | (pending & ~w1c_bits);
      if (wr_en && bus.address == ADDR_MASK) begin
        mask <= bus.writedata[NUM_SRC-1:0];
      end
      if (wr_en && bus.address == ADDR_CTRL) begin
        coal_en <= bus.writedata[0];
        cnt_th  <= bus.writedata[15:8];
      end
      if (wr_en && bus.address == ADDR_TIMEOUT) begin
        timeout <= bus.writedata[TIMER_W-1:0];
      end
    end
  end

  // Coalescing FSM next-state logic; with coalescing off it is parked in IDLE and irq follows mp.
  always_comb begin
    state_nxt = state;
    evcnt_nxt = evcnt;
    timer_nxt = timer;
    irq_nxt   = 1'b0;
    if (!coal_en) begin
      state_nxt = IDLE;
      evcnt_nxt = 8'd0;
      timer_nxt = '0;
      irq_nxt   = |mp;
    end else begin
      case (state)
        IDLE: begin
          if (nev != '0) begin
            evcnt_nxt = 8'(nev);
            timer_nxt = '0;
            state_nxt = (8'(nev) >= threshold) ? FIRE : ACCUM;
          end else if (|mp) begin
            state_nxt = FIRE;
          end
        end
        ACCUM: begin
          evcnt_nxt = evcnt_sat;
          timer_nxt = timer_sat;
          if ((evcnt_sat >= threshold) || timeout_hit) begin
            state_nxt = FIRE;
          end else if (mp == '0) begin
            state_nxt = IDLE;
            evcnt_nxt = 8'd0;
            timer_nxt = '0;
          end
        end
        FIRE: begin
          if (|mp) begin
            irq_nxt   = 1'b1;
            evcnt_nxt = evcnt_sat;
          end else begin
            state_nxt = IDLE;
            evcnt_nxt = 8'd0;
            timer_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          evcnt_nxt = 8'd0;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // Coalescing FSM state, counters and the registered irq output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      evcnt <= 8'd0;
      timer <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_nxt;
      evcnt <= evcnt_nxt;
      timer <= timer_nxt;
      irq   <= irq_nxt;
    end
  end

  // Read multiplexer; unused bits and unmapped addresses return zero.
  always_comb begin
    rd_mux = 32'd0;
    case (bus.address)
      ADDR_STATUS:  rd_mux = 32'(d2);
      ADDR_PENDING: rd_mux = 32'(pending);
      ADDR_MASK:    rd_mux = 32'(mask);
      ADDR_CTRL:    rd_mux = {16'd0, cnt_th, 7'd0, coal_en};
      ADDR_TIMEOUT: rd_mux = 32'(timeout);
      ADDR_VECTOR:  rd_mux = {|mp, 27'd0, vec_idx};
      ADDR_EVCNT:   rd_mux = {24'd0, evcnt};
      default:      rd_mux = 32'd0;
    endcase
  end

  // Registered read data, refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'd0;
    end else begin
      bus.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_eth_irq_coalescer.sv
// Scoreboard bench for eth_irq_coalescer: stimulus queues expected values,
// monitors pop and compare when a read completes or an irq probe is raised.
module tb_eth_irq_coalescer;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_PENDING = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_CTRL    = 3'd3;
  localparam logic [2:0] A_TIMEOUT = 3'd4;
  localparam logic [2:0] A_VECTOR  = 3'd5;
  localparam logic [2:0] A_EVCNT   = 3'd6;

  typedef struct {
    string       name;
    bit          on_readdata;
    logic [31:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] src_in = 8'd0;
  logic       irq;
  logic       rd_valid_q = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  chk_t rd_q[$];
  chk_t probe_q[$];
  event probe_ev;

  eth_irq_coalescer_if bus();

  eth_irq_coalescer #(
    .NUM_SRC(8),
    .TIMER_W(16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .src_in  (src_in),
    .irq     (irq)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Remember whether the edge just taken carried a read so readdata is checked mid-cycle.
  always @(posedge clk) begin
    rd_valid_q <= bus.chipselect && bus.write_n;
  end

  // Read monitor: each completed read consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rd_valid_q) begin
      if (rd_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read", bus.readdata);
      end else begin
        chk_t e;
        e = rd_q.pop_front();
        compare(e.name, bus.readdata, e.exp);
      end
    end
  end

  // Probe monitor: drains every queued irq/readdata probe when signalled.
  initial begin
    forever begin
      @(probe_ev);
      while (probe_q.size() > 0) begin
        chk_t e;
        e = probe_q.pop_front();
        if (e.on_readdata) compare(e.name, bus.readdata, e.exp);
        else               compare(e.name, {31'd0, irq}, e.exp);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] src);
    src_in = src;
  endtask

  task automatic checkOutput(input string name, input bit on_readdata, input logic [31:0] exp);
    chk_t e;
    e.name = name;
    e.on_readdata = on_readdata;
    e.exp = exp;
    probe_q.push_back(e);
    -> probe_ev;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [2:0] a, input logic [31:0] exp, input string name);
    chk_t e;
    e.name = name;
    e.on_readdata = 1'b1;
    e.exp = exp;
    rd_q.push_back(e);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick();
    bus.chipselect = 1'b0;
  endtask

  // One-cycle pulse on a source; returns just after the edge where PENDING/EVCNT update.
  task automatic pulseSrc(input int idx);
    applyStimulus(8'(1 << idx));
    tick();
    applyStimulus(8'h00);
    tick();
    tick();
  endtask

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("reset_irq", 1'b0, 32'd0);
    checkOutput("reset_readdata", 1'b1, 32'd0);
    readReg(A_PENDING, 32'd0, "reset_pending");
    readReg(A_MASK,    32'd0, "reset_mask");
    readReg(A_CTRL,    32'd0, "reset_ctrl");

    $display("[TB] direct mode");
    writeReg(A_MASK, 32'h01);
    applyStimulus(8'h01);
    tick();
    tick();
    tick();
    checkOutput("direct_irq_e2", 1'b0, 32'd0);
    tick();
    checkOutput("direct_irq_e3", 1'b0, 32'd1);
    applyStimulus(8'h00);
    readReg(A_PENDING, 32'h01, "direct_pending");
    readReg(A_VECTOR,  32'h8000_0000, "direct_vector");
    writeReg(A_PENDING, 32'h01);
    checkOutput("w1c_irq_same_edge", 1'b0, 32'd1);
    tick();
    checkOutput("w1c_irq_next_edge", 1'b0, 32'd0);

    $display("[TB] masking");
    writeReg(A_MASK, 32'h00);
    pulseSrc(2);
    tick();
    checkOutput("masked_irq", 1'b0, 32'd0);
    readReg(A_PENDING, 32'h04, "masked_pending");
    writeReg(A_MASK, 32'h04);
    checkOutput("unmask_irq_same_edge", 1'b0, 32'd0);
    tick();
    checkOutput("unmask_irq_next_edge", 1'b0, 32'd1);
    readReg(A_VECTOR, 32'h8000_0002, "unmask_vector");
    writeReg(A_PENDING, 32'h04);
    tick();
    checkOutput("unmask_clear_irq", 1'b0, 32'd0);

    $display("[TB] count threshold");
    writeReg(A_MASK, 32'hFF);
    writeReg(A_TIMEOUT, 32'd0);
    writeReg(A_CTRL, 32'h0000_0301);
    pulseSrc(1);
    repeat (8) tick();
    checkOutput("cnt_irq_after1", 1'b0, 32'd0);
    readReg(A_EVCNT, 32'd1, "cnt_evcnt1");
    pulseSrc(4);
    repeat (8) tick();
    checkOutput("cnt_irq_after2", 1'b0, 32'd0);
    readReg(A_EVCNT, 32'd2, "cnt_evcnt2");
    pulseSrc(6);
    checkOutput("cnt_irq_enter_fire", 1'b0, 32'd0);
    tick();
    checkOutput("cnt_irq_fire", 1'b0, 32'd1);
    readReg(A_EVCNT,   32'd3,  "cnt_evcnt3");
    readReg(A_PENDING, 32'h52, "cnt_pending");
    writeReg(A_PENDING, 32'h52);
    checkOutput("cnt_clear_same_edge", 1'b0, 32'd1);
    tick();
    checkOutput("cnt_clear_irq", 1'b0, 32'd0);
    readReg(A_EVCNT, 32'd0, "cnt_clear_evcnt");

    $display("[TB] timeout");
    writeReg(A_CTRL, 32'h0000_0A01);
    writeReg(A_TIMEOUT, 32'd20);
    pulseSrc(0);
    repeat (20) tick();
    checkOutput("tmo_irq_before", 1'b0, 32'd0);
    tick();
    checkOutput("tmo_irq_fire", 1'b0, 32'd1);
    readReg(A_EVCNT, 32'd1, "tmo_evcnt");
    writeReg(A_PENDING, 32'h01);
    tick();
    checkOutput("tmo_clear_irq", 1'b0, 32'd0);

    $display("[TB] collision");
    writeReg(A_CTRL, 32'd0);
    pulseSrc(3);
    applyStimulus(8'h08);
    tick();
    applyStimulus(8'h00);
    tick();
    writeReg(A_PENDING, 32'h08);
    readReg(A_PENDING, 32'h08, "collide_pending");
    writeReg(A_PENDING, 32'h08);
    readReg(A_PENDING, 32'h00, "plain_w1c_pending");

    $display("[TB] saturation");
    writeReg(A_TIMEOUT, 32'd0);
    writeReg(A_CTRL, 32'h0000_FF01);
    for (int i = 0; i < 38; i++) begin
      applyStimulus(8'hFF);
      tick();
      applyStimulus(8'h00);
      tick();
    end
    repeat (4) tick();
    checkOutput("sat_irq", 1'b0, 32'd1);
    readReg(A_EVCNT,   32'd255, "sat_evcnt");
    readReg(A_PENDING, 32'hFF,  "sat_pending");
    tick();

    $display("[TB] reset abort");
    reset_n = 1'b0;
    #1;
    checkOutput("abort_irq", 1'b0, 32'd0);
    checkOutput("abort_readdata", 1'b1, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    readReg(A_EVCNT,   32'd0, "abort_evcnt");
    readReg(A_PENDING, 32'd0, "abort_pending");
    readReg(A_CTRL,    32'd0, "abort_ctrl");

    $display("[TB] coalescing disable");
    writeReg(A_MASK, 32'hFF);
    writeReg(A_CTRL, 32'h0000_0A01);
    pulseSrc(5);
    tick();
    tick();
    checkOutput("dis_irq_accum", 1'b0, 32'd0);
    readReg(A_EVCNT, 32'd1, "dis_evcnt_accum");
    writeReg(A_CTRL, 32'h0000_0A00);
    checkOutput("dis_irq_same_edge", 1'b0, 32'd0);
    tick();
    checkOutput("dis_irq_direct", 1'b0, 32'd1);
    readReg(A_EVCNT,  32'd0,         "dis_evcnt");
    readReg(A_CTRL,   32'h0000_0A00, "dis_ctrl");
    readReg(A_STATUS, 32'd0,         "dis_status");
    tick();
    tick();

    while (rd_q.size() > 0) begin
      chk_t e;
      e = rd_q.pop_front();
      total_cnt++;
      $display("[TB] FAIL %s: got no read, expected 0x%08h", e.name, e.exp);
    end
    while (probe_q.size() > 0) begin
      chk_t e;
      e = probe_q.pop_front();
      total_cnt++;
      $display("[TB] FAIL %s: got no sample, expected 0x%08h", e.name, e.exp);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/eth_irq_coalescer.md
# eth_irq_coalescer

Interrupt controller for the Nios II Ethernet subsystem. It aggregates up to NUM_SRC level event lines from the MAC/DMA into edge-captured pending bits, each with its own mask, and presents them to the CPU over an Avalon-MM slave. It drives a single `irq` line, either directly or through count/timeout interrupt coalescing.

## Interface
- NUM_SRC, 8: number of event sources, 1..16.
- TIMER_W, 16: width of the timeout counter and TIMEOUT register.

- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data; reset value 0.
- src_in  in  NUM_SRC  asynchronous event levels; each rising edge is one event.
- irq  out  1  registered interrupt request; reset value 0.

## Operation
- Input path: each src_in bit passes through a 2-flop synchronizer (d1, d2) plus a third flop d3.
  - edge[i] = d2[i] & ~d3[i].
  - All flops reset to 0.
- Register map (unused bits read 0, writes to RO registers ignored):
  - 0 STATUS, RO: d2 synchronized levels.
  - 1 PENDING, W1C: sticky edge capture.
  - 2 MASK, RW: 1 = source enabled.
  - 3 CTRL, RW: bit0 COAL_EN; bits[15:8] CNT_TH.
  - 4 TIMEOUT, RW: TIMER_W bits.
  - 5 VECTOR, RO: bit31 = |mp; bits[3:0] = lowest index i with mp[i]=1, 0 if none.
  - 6 EVCNT, RO: coalescing event counter, 8 bits.
  - 7: reads 0.
- mp = PENDING & MASK.
- PENDING bit update per cycle: set if edge[i]; else cleared if written with writedata[i]=1; else held.
  - A simultaneous edge and W1C on the same bit leaves the bit set.
  - Edges set PENDING regardless of MASK.
- Reset values: PENDING=0, MASK=0, CTRL=0, TIMEOUT=0, EVCNT=0, timer=0, state=IDLE.
- nev = popcount(edge & MASK) in the current cycle.
- Direct mode (COAL_EN=0): irq <= |mp every cycle. The FSM is held in IDLE with EVCNT=0 and timer=0.
- Coalescing mode (COAL_EN=1): FSM with states IDLE, ACCUM, FIRE.
  - IDLE:
    - If nev>0: EVCNT<=nev and timer<=0. Go to FIRE if nev>=max(CNT_TH,1), else go to ACCUM.
    - Otherwise, if mp!=0 (pending left over from direct mode), go straight to FIRE.
  - ACCUM:
    - EVCNT<=min(EVCNT+nev,255); timer<=timer+1, saturating.
    - Go to FIRE when the updated EVCNT>=max(CNT_TH,1), or when TIMEOUT!=0 and timer+1>=TIMEOUT.
    - Go to IDLE with EVCNT<=0 if mp==0, i.e. software cleared or masked everything.
  - FIRE:
    - irq <= 1 while mp!=0. EVCNT keeps counting with saturation.
    - Go to IDLE when mp==0, with EVCNT<=0, timer<=0 and irq<=0.
  - irq <= 0 in IDLE and ACCUM.
- Writing COAL_EN 1->0 in any state forces IDLE, clears EVCNT and timer, and switches irq to direct mode on the next edge.
- Writing CTRL or TIMEOUT during ACCUM takes effect on the next comparison; counters are not restarted.
- TIMEOUT=0 disables the timeout; only the count threshold fires.

## Timing
- readdata <= mux(address) on every clock regardless of chipselect, giving 1-cycle read latency.
- Reads have no side effects.
- src_in first sampled high at edge E0:
  - edge is high between E1 and E2.
  - PENDING and EVCNT update at E2.
  - Direct-mode irq rises at E3.
- Coalescing: irq rises on the edge after the FSM enters FIRE.
- W1C at edge W clears the bit at W. In direct mode irq falls at W+1 if no other mp bit is set.
- Writes take effect on the same edge. Register reads reflect a write one edge later.
- reset_n low clears all state asynchronously, including in mid-ACCUM or FIRE; irq and readdata go to 0 immediately.

## Test plan
- Reset, then direct mode with MASK=0x01: pulse src_in[0] for 4 cycles -> irq rises 3 edges after first sample. PENDING reads 0x01. Write 0x01 to PENDING -> irq low one edge later.
- Masking, direct mode: MASK=0x00, src_in[2] rising edge -> PENDING=0x04, irq stays 0. Write MASK=0x04 -> irq=1 next edge. VECTOR reads 0x80000002.
- Count threshold: COAL_EN=1, CNT_TH=3, TIMEOUT=0, MASK=0xFF. Edges on src 1, 4, 6 spaced 10 cycles apart -> irq stays 0 after two events and rises after the third. EVCNT=3. Write PENDING=0x52 -> irq 0, EVCNT=0, state IDLE.
- Timeout: CNT_TH=10, TIMEOUT=20, single edge on src 0 -> irq rises about 21 cycles after PENDING sets. EVCNT=1.
- Collision and saturation: same-cycle edge and W1C on bit 3 -> bit 3 stays 1. 300 masked events in ACCUM with CNT_TH=255 -> EVCNT saturates at 255 and FIRE is entered.
- Mid-operation abort: assert reset_n low in FIRE -> irq=0 and readdata=0 immediately. Clearing COAL_EN in ACCUM with pending set -> direct-mode irq=1 next edge.
